trace_buffer_triggered: RTL and testbench
=========================================

Name: trace_buffer_triggered

Overview:
Multi-mode circular trace buffer storing N-lane vectors of DATA_WIDTH bits, TB_SIZE entries deep, in a single dual-port RAM (port A write, port B read, 1-cycle read latency). Generalises the free-running trace buffer with capture modes, a trigger with programmable post-trigger depth, fill/wrap tracking and an oldest-first dump stream with valid/ready handshake. It sits at the end of the debug datapath and feeds the readout/host interface.

Parameters:
N, 8, vector lanes
DATA_WIDTH, 32, bits per lane
TB_SIZE, 64, entries; power of two >= 2
AW, $clog2(TB_SIZE), address width (derived, not overridable)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  pulse: clear pointers and begin capture
stop  in  1  pulse: end capture, freeze contents
mode  in  2  0=continuous wrap, 1=stop-when-full, 2=triggered, 3=reserved (behaves as 0)
post_count  in  AW+1  entries to capture after trigger, 0..TB_SIZE (mode 2)
trigger  in  1  trigger event (mode 2)
valid_in  in  1  vector_in valid
vector_in  in  N x DATA_WIDTH  input vector
dump_req  in  1  pulse: stream stored contents oldest-first
vector_out  out  N x DATA_WIDTH  dump data
out_valid  out  1  vector_out valid
out_ready  in  1  consumer accepts vector_out
out_last  out  1  marks final dump entry
fill  out  AW+1  stored entries, saturates at TB_SIZE
wrapped  out  1  write pointer has wrapped since start
triggered  out  1  trigger accepted since start
trig_addr  out  AW  write address at trigger cycle
state  out  3  IDLE=0, ARMED=1, POST=2, FROZEN=3, DUMP=4

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, wr_ptr=0, fill=0, wrapped=0, triggered=0, trig_addr=0, out_valid=0, out_last=0, vector_out=0. No RAM writes during reset. Reset mid-dump or mid-capture aborts immediately; RAM contents undefined-but-retained.
- mode and post_count are sampled on start; changes during capture are ignored.
- IDLE/FROZEN: start -> ARMED (wr_ptr, fill, wrapped, triggered cleared). dump_req -> DUMP. start and dump_req together: start wins. Other inputs ignored.
- ARMED: each valid_in writes vector_in to RAM[wr_ptr]; wr_ptr increments mod TB_SIZE; fill += 1 saturating at TB_SIZE; wrapped set when wr_ptr goes TB_SIZE-1 -> 0.
  - stop -> FROZEN; beat with stop asserted is NOT written.
  - mode 1: the write making fill==TB_SIZE is the last; next state FROZEN; no overwrite.
  - mode 2: trigger (valid_in not required) sets triggered=1, trig_addr=wr_ptr. post_count==0 -> FROZEN, triggering beat not written. Else -> POST with remaining=post_count; triggering beat, if valid, is written and counts as 1 (remaining reaching 0 -> FROZEN directly).
- POST: valid writes as ARMED, remaining decrements per write; write bringing remaining to 0 -> FROZEN. Further triggers ignored. stop -> FROZEN early.
- DUMP: read base = wrapped ? wr_ptr : 0; reads fill entries, address incrementing mod TB_SIZE. fill==0: return to IDLE next cycle, out_valid never asserts. Otherwise first out_valid 2 cycles after dump_req (address register + RAM latency). Handshake: beat transfers when out_valid&&out_ready; while out_valid&&!out_ready vector_out, out_last hold stable. Sustained 1 beat/cycle with out_ready=1 (prefetch/skid register required). out_last=1 with the final entry; after its transfer out_valid=0, state -> IDLE. Contents, fill, wrapped retained; dump repeatable. valid_in, start, stop, trigger ignored in DUMP.
- Writes never occur outside ARMED/POST.

Test Plan:
- Mode 0, TB_SIZE=8, start, 5 valid beats 1..5, stop, dump_req, out_ready=1 -> fill=5, wrapped=0, stream 1,2,3,4,5, out_last on 5, first out_valid 2 cycles after dump_req.
- Mode 0, 11 beats 1..11, stop, dump -> wrapped=1, fill=8, stream 4..11.
- Mode 1, 10 beats 1..10 -> FROZEN after beat 8, fill=8, dump 1..8.
- Mode 2, post_count=3, beats 1..20, trigger with beat 10 -> triggered=1, trig_addr=1 (10th write mod 8 = addr 1), frozen after beat 12, dump 5..12; repeat with post_count=0 -> dump 2..9.
- Dump with out_ready toggling 1,0,0,1 pattern -> no beat lost/duplicated, vector_out stable while stalled; dump_req with fill=0 -> no out_valid, back to IDLE.
- reset_n=0 mid-dump and mid-POST -> all outputs reset values next cycle, state IDLE; start+dump_req same cycle -> ARMED.

Source files
------------

// File: rtl/trace_buffer_triggered.sv
// Multi-mode circular trace buffer with trigger, post-trigger capture
// and an oldest-first valid/ready dump stream.
module trace_buffer_triggered #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 64,
  localparam int AW        = $clog2(TB_SIZE),
  localparam int W         = N * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [AW:0]   post_count,
  input  logic          trigger,
  input  logic          valid_in,
  input  logic [W-1:0]  vector_in,
  input  logic          dump_req,
  output logic [W-1:0]  vector_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW:0]   fill,
  output logic          wrapped,
  output logic          triggered,
  output logic [AW-1:0] trig_addr,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    POST   = 3'd2,
    FROZEN = 3'd3,
    DUMP   = 3'd4
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(TB_SIZE);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t st, st_nx;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] base;
  logic [AW-1:0] taddr_q;
  logic [AW:0]   fill_q;
  logic [AW:0]   rem;
  logic [AW:0]   left;
  logic [AW:0]   post_q;
  logic [1:0]    mode_q;
  logic          wrapped_q;
  logic          trig_q;

  logic [W-1:0]  mem [TB_SIZE];
  logic [W-1:0]  q_data;
  logic [W-1:0]  d0;
  logic [W-1:0]  d1;
  logic          q_v;
  logic          q_last;
  logic          l0;
  logic          l1;
  logic [1:0]    cnt;

  logic we;
  logic re;
  logic re_last;
  logic cap_start;
  logic dump_start;
  logic trig_fire;
  logic pop;
  logic room;

  assign base = wrapped_q ? wr_ptr : '0;
  assign pop  = (cnt != 2'd0) && out_ready;

  // a read may issue only if its data is guaranteed a slot in the 2-entry skid
  assign room = ({1'b0, cnt} + {2'b0, q_v}) <= ({2'b0, pop} + 3'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE, FROZEN: begin
        if (start)         st_nx = ARMED;
        else if (dump_req) st_nx = DUMP;
      end
      ARMED: begin
        if (stop) begin
          st_nx = FROZEN;
        end else if (mode_q == 2'd2 && trigger) begin
          if (post_q == '0 || (valid_in && post_q == ONE))
            st_nx = FROZEN;
          else
            st_nx = POST;
        end else if (valid_in && mode_q == 2'd1 &&
                     fill_q == FULL - ONE) begin
          st_nx = FROZEN;
        end
      end
      POST: begin
        if (stop || (valid_in && rem == ONE)) st_nx = FROZEN;
      end
      DUMP: begin
        if ((pop && l0) ||
            (left == '0 && !q_v && cnt == 2'd0))
          st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    cap_start  = 1'b0;
    dump_start = 1'b0;
    we         = 1'b0;
    trig_fire  = 1'b0;
    re         = 1'b0;
    re_last    = 1'b0;
    raddr      = rd_addr;
    unique case (st)
      IDLE, FROZEN: begin
        cap_start  = start;
        dump_start = !start && dump_req;
      end
      ARMED: begin
        trig_fire = !stop && mode_q == 2'd2 && trigger;
        we = !stop && valid_in &&
             !(trig_fire && post_q == '0);
      end
      POST: we = !stop && valid_in;
      DUMP: begin
        re      = left != '0 && room;
        re_last = left == ONE;
      end
      default: ;
    endcase
    // first read goes out in the accept cycle to hit two-cycle latency
    if (dump_start) begin
      re      = fill_q != '0;
      re_last = fill_q == ONE;
      raddr   = base;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
      trig_q    <= 1'b0;
      taddr_q   <= '0;
      mode_q    <= '0;
      post_q    <= '0;
      rem       <= '0;
      rd_addr   <= '0;
      left      <= '0;
    end else begin
      if (cap_start) begin
        wr_ptr    <= '0;
        fill_q    <= '0;
        wrapped_q <= 1'b0;
        trig_q    <= 1'b0;
        mode_q    <= mode;
        post_q    <= post_count;
      end
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_q != FULL) fill_q <= fill_q + ONE;
        if (wr_ptr == '1)   wrapped_q <= 1'b1;
      end
      if (trig_fire) begin
        trig_q  <= 1'b1;
        taddr_q <= wr_ptr;
        rem     <= post_q - (valid_in ? ONE : '0);
      end else if (we) begin
        rem <= rem - ONE;
      end
      if (dump_start) begin
        rd_addr <= base + 1'b1;
        left    <= fill_q - ((fill_q != '0) ? ONE : '0);
      end else if (re) begin
        rd_addr <= rd_addr + 1'b1;
        left    <= left - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && reset_n) mem[wr_ptr] <= vector_in;
    if (re && reset_n) q_data <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_v    <= 1'b0;
      q_last <= 1'b0;
      cnt    <= 2'd0;
      d0     <= '0;
      d1     <= '0;
      l0     <= 1'b0;
      l1     <= 1'b0;
    end else begin
      q_v    <= re;
      q_last <= re && re_last;
      unique case ({pop, q_v})
        2'b01: begin
          if (cnt == 2'd0) begin
            d0 <= q_data;
            l0 <= q_last;
          end else begin
            d1 <= q_data;
            l1 <= q_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b10: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= q_data;
            l0 <= q_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= q_data;
            l1 <= q_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign vector_out = d0;
  assign out_valid  = cnt != 2'd0;
  assign out_last   = l0 && out_valid;
  assign fill       = fill_q;
  assign wrapped    = wrapped_q;
  assign triggered  = trig_q;
  assign trig_addr  = taddr_q;
  assign state      = st;

endmodule

// File: tb/tb_trace_buffer_triggered.sv
// Bench for trace_buffer_triggered: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_trace_buffer_triggered;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int TB = 8;
  localparam int AW = 3;
  localparam int W  = N * DW;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [AW:0]   post_count;
  logic          trigger;
  logic          valid_in;
  logic [W-1:0]  vector_in;
  logic          dump_req;
  logic [W-1:0]  vector_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW:0]   fill;
  logic          wrapped;
  logic          triggered;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state;

  trace_buffer_triggered #(
    .N(N), .DATA_WIDTH(DW), .TB_SIZE(TB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .mode(mode), .post_count(post_count), .trigger(trigger),
    .valid_in(valid_in), .vector_in(vector_in),
    .dump_req(dump_req), .vector_out(vector_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .fill(fill), .wrapped(wrapped),
    .triggered(triggered), .trig_addr(trig_addr), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: states 0 idle,1 armed,2 post,3 frozen,4 dump
  int mstate = 0;
  int mtotal = 0;
  int mmode  = 0;
  int mpost  = 0;
  int mrem   = 0;
  int mtaddr = 0;
  bit mtrig  = 0;
  bit dump_empty = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] expq[$];
  logic [W-1:0] got[$];

  bit           stalled = 0;
  logic [W-1:0] held;
  logic         held_last;
  int           beat_cycles = 0;
  bit           lat1;
  bit           lat2;

  function automatic logic [W-1:0] mk(int v);
    return {DW'(v + 256), DW'(v)};
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mwrite();
    hist.push_back(vector_in);
    if (hist.size() > TB) void'(hist.pop_front());
    mtotal++;
  endtask

  task automatic model_step(bit last_hs);
    if (!reset_n) begin
      mstate = 0;
      mtotal = 0;
      mtrig  = 0;
      mtaddr = 0;
      hist.delete();
      expq.delete();
      return;
    end
    case (mstate)
      0, 3: begin
        if (start) begin
          mstate = 1;
          hist.delete();
          mtotal = 0;
          mtrig  = 0;
          mmode  = mode;
          mpost  = post_count;
        end else if (dump_req) begin
          mstate = 4;
          expq = hist;
          dump_empty = hist.size() == 0;
        end
      end
      1: begin
        if (stop) mstate = 3;
        else if (mmode == 2 && trigger) begin
          mtrig  = 1;
          mtaddr = mtotal % TB;
          if (mpost == 0) mstate = 3;
          else begin
            mrem = mpost;
            if (valid_in) begin
              mwrite();
              mrem--;
            end
            mstate = (mrem == 0) ? 3 : 2;
          end
        end else if (valid_in) begin
          mwrite();
          if (mmode == 1 && mtotal == TB) mstate = 3;
        end
      end
      2: begin
        if (stop) mstate = 3;
        else if (valid_in) begin
          mwrite();
          mrem--;
          if (mrem == 0) mstate = 3;
        end
      end
      4: if (dump_empty || last_hs) mstate = 0;
      default: mstate = 0;
    endcase
  endtask

  task automatic compare();
    check("state", state, mstate);
    check("fill", fill, hist.size());
    check("wrapped", wrapped, mtotal >= TB);
    check("triggered", triggered, mtrig);
    check("trig_addr", trig_addr, mtaddr);
    if (mstate != 4 || dump_empty)
      check("quiet_out_valid", out_valid, 0);
  endtask

  task automatic cyc();
    bit last_hs;
    last_hs = 0;
    if (reset_n && stalled) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", vector_out, held);
      check("stall_last", out_last, held_last);
    end
    stalled = 0;
    if (reset_n && out_valid) begin
      beat_cycles++;
      if (out_ready) begin
        got.push_back(vector_out);
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL extra_beat got %0h want none", vector_out);
        end else begin
          check("beat_data", vector_out, expq[0]);
          check("beat_last", out_last, expq.size() == 1);
          void'(expq.pop_front());
          if (expq.size() == 0) last_hs = 1;
        end
      end else begin
        stalled   = 1;
        held      = vector_out;
        held_last = out_last;
      end
    end
    @(posedge clk);
    model_step(last_hs);
    @(negedge clk);
    compare();
  endtask

  task automatic quiet();
    start = 0; stop = 0; trigger = 0; valid_in = 0;
    dump_req = 0; out_ready = 1; reset_n = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    cyc();
    reset_n = 1;
  endtask

  task automatic cap(int md, int pc, int nb, int trig_at, bit do_stop);
    start = 1; mode = 2'(md); post_count = 4'(pc);
    cyc();
    start = 0;
    for (int b = 1; b <= nb; b++) begin
      valid_in  = 1;
      vector_in = mk(b);
      trigger   = (b == trig_at);
      cyc();
    end
    valid_in = 0; trigger = 0;
    if (do_stop) begin
      stop = 1;
      cyc();
      stop = 0;
    end
  endtask

  task automatic dump(int n, bit stall);
    got.delete();
    beat_cycles = 0;
    out_ready = 1;
    dump_req = 1;
    cyc();
    lat1 = out_valid;
    dump_req = 0;
    cyc();
    lat2 = out_valid;
    for (int i = 0; i < 100 && mstate == 4; i++) begin
      out_ready = stall ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      cyc();
    end
    out_ready = 1;
    check("dump_done", mstate, 0);
    check("lat_cycle1", lat1, 0);
    check("lat_cycle2", lat2, n != 0);
    if (!stall) check("sustained", beat_cycles, n);
  endtask

  task automatic check_stream(string nm, int first, int n);
    check({nm, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check(nm, got[i], mk(first + i));
  endtask

  initial begin
    quiet();
    reset_n = 0; mode = 0; post_count = 0; vector_in = 0;
    @(negedge clk);
    do_reset();
    check("rst_vec", vector_out, 0);
    check("rst_last", out_last, 0);

    cap(0, 0, 5, 0, 1);
    check("t1_fill", fill, 5);
    check("t1_wrap", wrapped, 0);
    dump(5, 0);
    check_stream("t1_stream", 1, 5);

    cap(0, 0, 11, 0, 1);
    check("t2_fill", fill, 8);
    check("t2_wrap", wrapped, 1);
    dump(8, 0);
    check_stream("t2_stream", 4, 8);

    cap(1, 0, 10, 0, 0);
    check("t3_state", state, 3);
    check("t3_fill", fill, 8);
    dump(8, 0);
    check_stream("t3_stream", 1, 8);

    cap(2, 3, 20, 10, 0);
    check("t4_trig", triggered, 1);
    check("t4_taddr", trig_addr, 1);
    check("t4_state", state, 3);
    dump(8, 0);
    check_stream("t4_stream", 5, 8);

    cap(2, 0, 20, 10, 0);
    check("t5_taddr", trig_addr, 1);
    dump(8, 0);
    check_stream("t5_stream", 2, 8);

    dump(8, 1);
    check_stream("t6_stall_stream", 2, 8);

    do_reset();
    dump_req = 1;
    cyc();
    check("t7_dump_state", state, 4);
    dump_req = 0;
    cyc();
    check("t7_idle", state, 0);
    check("t7_no_valid", out_valid, 0);

    cap(0, 0, 6, 0, 1);
    dump_req = 1;
    cyc();
    dump_req = 0;
    cyc();
    cyc();
    do_reset();
    check("t8_state", state, 0);
    check("t8_valid", out_valid, 0);
    check("t8_vec", vector_out, 0);
    check("t8_last", out_last, 0);
    check("t8_fill", fill, 0);

    cap(2, 8, 3, 2, 0);
    check("t9_post", state, 2);
    do_reset();
    check("t9_state", state, 0);
    check("t9_trig", triggered, 0);
    check("t9_taddr", trig_addr, 0);

    start = 1; dump_req = 1; mode = 0;
    cyc();
    start = 0; dump_req = 0;
    check("t10_armed", state, 1);
    stop = 1;
    cyc();
    stop = 0;

    for (int i = 0; i < 1500; i++) begin
      reset_n    = ($urandom % 200) != 0;
      start      = ($urandom % 40) == 0;
      stop       = ($urandom % 60) == 0;
      dump_req   = ($urandom % 30) == 0;
      trigger    = ($urandom % 25) == 0;
      valid_in   = ($urandom % 10) < 7;
      out_ready  = ($urandom % 10) < 6;
      mode       = 2'($urandom % 4);
      post_count = 4'($urandom % (TB + 1));
      vector_in  = W'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
